// File: rtl/truth_table_checker.sv
// Walks a 2-input DUT through 00,01,10,11, samples s after SETTLE+1 cycles per row, and grades the table.
// Latency from accepted start to done is 4*(SETTLE+1) edges; start is ignored while busy, abort cancels a run.
module truth_table_checker #(
  parameter int SETTLE = 1
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_abort,
  input  logic [3:0] i_expect_tt,
  input  logic       i_s,
  output logic       o_a,
  output logic       o_b,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [3:0] o_observed,
  output logic [3:0] o_mismatch
);

  localparam int CW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [CW-1:0] SETTLE_C = CW'(SETTLE);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t        r_state, w_state_nxt;
  logic [1:0]    r_idx, w_idx_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic          r_a, w_a_nxt;
  logic          r_b, w_b_nxt;
  logic          r_done, w_done_nxt;
  logic          r_pass, w_pass_nxt;
  logic [3:0]    r_observed, w_observed_nxt;
  logic [3:0]    r_mismatch, w_mismatch_nxt;
  logic [3:0]    r_expect, w_expect_nxt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_cnt      <= '0;
      r_a        <= 1'b0;
      r_b        <= 1'b0;
      r_done     <= 1'b0;
      r_pass     <= 1'b0;
      r_observed <= '0;
      r_mismatch <= '0;
      r_expect   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cnt      <= w_cnt_nxt;
      r_a        <= w_a_nxt;
      r_b        <= w_b_nxt;
      r_done     <= w_done_nxt;
      r_pass     <= w_pass_nxt;
      r_observed <= w_observed_nxt;
      r_mismatch <= w_mismatch_nxt;
      r_expect   <= w_expect_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_idx_nxt      = r_idx;
    w_cnt_nxt      = r_cnt;
    w_a_nxt        = r_a;
    w_b_nxt        = r_b;
    w_done_nxt     = 1'b0;
    w_pass_nxt     = r_pass;
    w_observed_nxt = r_observed;
    w_mismatch_nxt = r_mismatch;
    w_expect_nxt   = r_expect;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          w_state_nxt    = ST_RUN;
          w_idx_nxt      = 2'd0;
          w_cnt_nxt      = SETTLE_C;
          w_a_nxt        = 1'b0;
          w_b_nxt        = 1'b0;
          w_pass_nxt     = 1'b0;
          w_observed_nxt = '0;
          w_mismatch_nxt = '0;
          w_expect_nxt   = i_expect_tt;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          // Partial observed/mismatch rows are kept for debug of the aborted run.
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = 2'd0;
          w_cnt_nxt   = '0;
          w_a_nxt     = 1'b0;
          w_b_nxt     = 1'b0;
        end else if (r_cnt != '0) begin
          w_cnt_nxt = r_cnt - CW'(1);
        end else begin
          w_observed_nxt[r_idx] = i_s;
          w_mismatch_nxt[r_idx] = i_s ^ r_expect[r_idx];
          if (r_idx != 2'd3) begin
            w_idx_nxt          = r_idx + 2'd1;
            {w_a_nxt, w_b_nxt} = r_idx + 2'd1;
            w_cnt_nxt          = SETTLE_C;
          end else begin
            w_state_nxt = ST_IDLE;
            w_idx_nxt   = 2'd0;
            w_a_nxt     = 1'b0;
            w_b_nxt     = 1'b0;
            w_done_nxt  = 1'b1;
            w_pass_nxt  = (w_observed_nxt == r_expect);
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign o_a        = r_a;
  assign o_b        = r_b;
  assign o_busy     = (r_state == ST_RUN);
  assign o_done     = r_done;
  assign o_pass     = r_pass;
  assign o_observed = r_observed;
  assign o_mismatch = r_mismatch;

endmodule

// File: tb/tb_truth_table_checker.sv
// Two checkers (SETTLE=1 and SETTLE=0) driving behavioural gate tables; a queue-based scoreboard grades each run.
module tb_truth_table_checker;

  typedef struct {
    int         e0;
    logic [3:0] expt;
    logic [3:0] gate;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start  [2];
  logic       abort  [2];
  logic [3:0] exp_tt [2];
  logic [3:0] gate   [2];
  logic       s_i    [2];
  logic       a_o    [2];
  logic       b_o    [2];
  logic       busy   [2];
  logic       done   [2];
  logic       pass   [2];
  logic [3:0] obs    [2];
  logic [3:0] mis    [2];

  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  rec_t q0[$];
  rec_t q1[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    truth_table_checker #(.SETTLE(1 - g)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_start     (start[g]),
      .i_abort     (abort[g]),
      .i_expect_tt (exp_tt[g]),
      .i_s         (s_i[g]),
      .o_a         (a_o[g]),
      .o_b         (b_o[g]),
      .o_busy      (busy[g]),
      .o_done      (done[g]),
      .o_pass      (pass[g]),
      .o_observed  (obs[g]),
      .o_mismatch  (mis[g])
    );
    assign s_i[g] = gate[g][{a_o[g], b_o[g]}];
  end

  function automatic int settle_of(input int u);
    return (u == 0) ? 1 : 0;
  endfunction

  task automatic chk(input string nm, input int u, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s[u%0d] @cyc %0d: got %0h, expected %0h", nm, u, cyc, act, req);
    end
  endtask

  function automatic logic [31:0] all_outs(input int u);
    return {19'd0, busy[u], done[u], pass[u], a_o[u], b_o[u], obs[u], mis[u]};
  endfunction

  // Scoreboard monitor: the front record of each queue describes the run in flight.
  always @(negedge clk) begin
    for (int u = 0; u < 2; u++) begin
      rec_t       r;
      bit         has;
      int         sd, lat, j;
      logic [1:0] pat;
      has = 1'b0;
      if (u == 0 && q0.size() > 0) begin has = 1'b1; r = q0[0]; end
      if (u == 1 && q1.size() > 0) begin has = 1'b1; r = q1[0]; end
      if (has && cyc >= r.e0) begin
        sd  = settle_of(u);
        lat = 4 * (sd + 1);
        j   = cyc - r.e0;
        if (j < lat) begin
          pat = 2'(j / (sd + 1));
          chk("run_ctl", u, {28'd0, busy[u], done[u], a_o[u], b_o[u]}, {28'd0, 2'b10, pat});
        end else begin
          chk("done_ctl", u, {28'd0, busy[u], done[u], a_o[u], b_o[u]}, 32'b0100);
          chk("observed", u, {28'd0, obs[u]}, {28'd0, r.gate});
          chk("mismatch", u, {28'd0, mis[u]}, {28'd0, r.gate ^ r.expt});
          chk("pass", u, {31'd0, pass[u]}, {31'd0, r.gate == r.expt});
          if (u == 0) void'(q0.pop_front());
          else        void'(q1.pop_front());
        end
      end else begin
        chk("no_done", u, {31'd0, done[u]}, 32'd0);
      end
    end
  end

  task automatic push_rec(input int u, input int e0, input logic [3:0] e, input logic [3:0] g);
    rec_t r;
    r.e0 = e0; r.expt = e; r.gate = g;
    if (u == 0) q0.push_back(r);
    else        q1.push_back(r);
  endtask

  // Called at posedge+#1 with the checker idle; returns at E0+#1 with start dropped.
  task automatic launch(input int u, input logic [3:0] e, input logic [3:0] g, input bit push, output int e0);
    gate[u]   = g;
    exp_tt[u] = e;
    start[u]  = 1'b1;
    e0 = cyc + 1;
    if (push) push_rec(u, e0, e, g);
    @(posedge clk); #1;
    start[u]  = 1'b0;
    exp_tt[u] = (($urandom & 1) != 0) ? 4'b1111 : 4'($urandom);
  endtask

  task automatic wait_idle(input int u);
    int n;
    for (int k = 0; k < 100; k++) begin
      n = (u == 0) ? q0.size() : q1.size();
      if (n == 0) break;
      @(posedge clk); #1;
    end
    n = (u == 0) ? q0.size() : q1.size();
    if (n != 0) begin
      chk("timeout", u, 32'(n), 32'd0);
      if (u == 0) q0.delete();
      else        q1.delete();
    end
  endtask

  // Held start: the second run launches on the edge after done and re-latches expect_tt.
  task automatic back_to_back(input int u, input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] g);
    int e0a, e0b;
    gate[u]   = g;
    exp_tt[u] = e1;
    start[u]  = 1'b1;
    e0a = cyc + 1;
    e0b = e0a + 4 * (settle_of(u) + 1) + 1;
    push_rec(u, e0a, e1, g);
    push_rec(u, e0b, e2, g);
    @(posedge clk); #1;
    exp_tt[u] = e2;
    while (cyc < e0b) begin @(posedge clk); #1; end
    start[u]  = 1'b0;
    exp_tt[u] = 4'($urandom);
  endtask

  initial begin
    int         e0;
    int         u;
    logic [3:0] e, g;
    rst_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; abort[k] = 1'b0; exp_tt[k] = 4'd0; gate[k] = 4'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", 0, all_outs(0), 32'd0);
    chk("reset_outs", 1, all_outs(1), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // s = a & ~b against its own table, then the faulty s = a | b.
    launch(0, 4'b0100, 4'b0100, 1'b1, e0); wait_idle(0);
    launch(0, 4'b0100, 4'b1110, 1'b1, e0); wait_idle(0);
    launch(1, 4'b0100, 4'b0100, 1'b1, e0); wait_idle(1);
    back_to_back(1, 4'b0100, 4'b1011, 4'b0100); wait_idle(1);
    back_to_back(0, 4'b1110, 4'b1110, 4'b1110); wait_idle(0);

    // Abort while row 2 is driven: rows 0 and 1 stay recorded.
    g = 4'b1001; e = 4'b0011;
    launch(0, e, g, 1'b0, e0);
    while (cyc < e0 + 4) begin @(posedge clk); #1; end
    abort[0] = 1'b1;
    @(posedge clk); #1;
    abort[0] = 1'b0;
    chk("abort_ctl", 0, {27'd0, busy[0], done[0], pass[0], a_o[0], b_o[0]}, 32'd0);
    chk("abort_obs", 0, {28'd0, obs[0]}, {30'd0, g[1:0]});
    chk("abort_mis", 0, {28'd0, mis[0]}, {30'd0, g[1:0] ^ e[1:0]});
    repeat (12) begin @(posedge clk); #1; end

    // Reset while row 1 is driven clears everything without a clock edge.
    launch(0, 4'b0110, 4'b0110, 1'b0, e0);
    while (cyc < e0 + 2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    chk("async_reset", 0, all_outs(0), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    launch(0, 4'b0110, 4'b0110, 1'b1, e0); wait_idle(0);

    for (int k = 0; k < 24; k++) begin
      u = k % 2;
      g = 4'($urandom);
      e = (($urandom & 1) != 0) ? g : 4'($urandom);
      launch(u, e, g, 1'b1, e0);
      wait_idle(u);
    end
    repeat (4) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
